// File: rtl/cell_bist_ctrl.sv
// Exhaustive-pattern BIST controller for one combinational library cell, MISR-compacted.
// Define CELL_BIST_GRAY_EN to apply patterns in Gray order (EXP_SIG must then be the Gray signature).
module cell_bist_ctrl #(
  parameter int unsigned       N_IN    = 3,
  parameter int unsigned       SETTLE  = 2,
  parameter int unsigned       SIG_W   = 16,
  parameter logic [SIG_W-1:0]  POLY    = 16'h1021,
  parameter logic [SIG_W-1:0]  EXP_SIG = 16'h34E2
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             START,
  output logic [N_IN-1:0]  PAT,
  input  logic             Y,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [SIG_W-1:0] SIG
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam int unsigned    SW     = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [SW-1:0]  S_LAST = SW'(SETTLE);
  // Index is one bit wider than the pattern so the last pattern is detected without wrapping.
  localparam logic [N_IN:0]  I_LAST = (N_IN + 1)'((1 << N_IN) - 1);

  logic [1:0]       state;
  logic [N_IN:0]    idx;
  logic [SW-1:0]    scnt;
  logic             capture;
  logic             last_pat;
  logic             fb;
  logic [SIG_W-1:0] misr_next;

  function automatic logic [N_IN-1:0] pat_map(input logic [N_IN-1:0] i);
`ifdef CELL_BIST_GRAY_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  assign capture   = (state == ST_RUN) && (scnt == S_LAST);
  assign last_pat  = (idx == I_LAST);
  assign fb        = SIG[SIG_W-1] ^ Y;
  assign misr_next = {SIG[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);

  assign BUSY = (state == ST_RUN);
  assign DONE = (state == ST_FIN);

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state <= ST_IDLE;
      idx   <= '0;
      scnt  <= '0;
      PAT   <= '0;
      SIG   <= '0;
      PASS  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            state <= ST_RUN;
            idx   <= '0;
            scnt  <= '0;
            SIG   <= '0;
            PASS  <= 1'b0;
            PAT   <= pat_map('0);
          end
        end
        ST_RUN: begin
          if (capture) begin
            SIG  <= misr_next;
            scnt <= '0;
            if (last_pat) begin
              state <= ST_FIN;
              // Compare against the value being loaded so PASS is valid alongside DONE.
              PASS  <= (misr_next == EXP_SIG);
            end else begin
              idx <= idx + 1'b1;
              PAT <= pat_map(idx[N_IN-1:0] + 1'b1);
            end
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
        ST_FIN: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_bist_ctrl.sv
// Scoreboard bench for cell_bist_ctrl: two instances (SETTLE=2 and SETTLE=0) around a behavioural AOI21.
module tb_cell_bist_ctrl;

`ifdef CELL_BIST_GRAY_EN
  localparam logic [15:0] EXP = 16'h9398;
`else
  localparam logic [15:0] EXP = 16'h34E2;
`endif

  typedef struct {
    int unsigned k;
    int unsigned st;
    logic [15:0] sig;
    logic        pass;
  } rec_t;

  logic        clk = 1'b0;
  logic        r;
  logic        start0, start1;
  logic        y0, y1;
  logic        stuck0, stuck1, glitch_en, g;
  logic [2:0]  pat0, pat1;
  logic        busy0, busy1, done0, done1, pass0, pass1;
  logic [15:0] sig0, sig1;

  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  rec_t        q0[$];
  rec_t        q1[$];
  rec_t        cur[2];
  logic        act[2];
  logic        hold[2];
  int          nbad[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic aoi21(input logic [2:0] p);
    return ~((p[2] & p[1]) | p[0]);
  endfunction

  function automatic logic [2:0] fpat(input int unsigned i);
    logic [2:0] b;
    b = 3'(i);
`ifdef CELL_BIST_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  // Y glitches mid-cycle but is settled again well before the next rising edge.
  always @(negedge clk) if (glitch_en) begin #1 g = 1'b1; #2 g = 1'b0; end

  assign y0 = stuck0 ? 1'b0 : (aoi21(pat0) ^ g);
  assign y1 = stuck1 ? 1'b0 : aoi21(pat1);

  cell_bist_ctrl #(.N_IN(3), .SETTLE(2), .SIG_W(16), .POLY(16'h1021), .EXP_SIG(EXP)) u0 (
    .CLK(clk), .R(r), .START(start0), .PAT(pat0), .Y(y0),
    .BUSY(busy0), .DONE(done0), .PASS(pass0), .SIG(sig0));

  cell_bist_ctrl #(.N_IN(3), .SETTLE(0), .SIG_W(16), .POLY(16'h1021), .EXP_SIG(EXP)) u1 (
    .CLK(clk), .R(r), .START(start1), .PAT(pat1), .Y(y1),
    .BUSY(busy1), .DONE(done1), .PASS(pass1), .SIG(sig1));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int qsize(input int id);
    return (id == 0) ? q0.size() : q1.size();
  endfunction

  function automatic rec_t qfront(input int id);
    if (id == 0) return q0[0];
    return q1[0];
  endfunction

  task automatic qpop(input int id);
    if (id == 0) void'(q0.pop_front());
    else         void'(q1.pop_front());
  endtask

  task automatic mon(input int id, input logic busy, input logic done, input logic pass,
                     input logic [2:0] pat, input logic [15:0] sig);
    int unsigned j;
    if (!r) begin
      act[id]  = 1'b0;
      hold[id] = 1'b0;
      return;
    end
    if (hold[id]) begin
      hold[id] = 1'b0;
      chk($sformatf("u%0d_pass_held", id), 32'(pass), 32'(cur[id].pass));
      chk($sformatf("u%0d_sig_held", id), 32'(sig), 32'(cur[id].sig));
    end
    if (!act[id] && (busy || done)) begin
      if (qsize(id) == 0) begin
        chk($sformatf("u%0d_unexpected_busy_done", id), {30'd0, busy, done}, 32'd0);
      end else begin
        cur[id]  = qfront(id);
        act[id]  = 1'b1;
        nbad[id] = 0;
        chk($sformatf("u%0d_busy_start_edge", id), cyc, cur[id].k);
      end
    end
    if (act[id]) begin
      if (busy) begin
        j = cyc - cur[id].k;
        if (pat !== fpat(j / (cur[id].st + 1))) nbad[id]++;
      end
      if (done) begin
        qpop(id);
        act[id]  = 1'b0;
        hold[id] = 1'b1;
        chk($sformatf("u%0d_done_edge", id), cyc, cur[id].k + 8 * (cur[id].st + 1));
        chk($sformatf("u%0d_busy_at_done", id), 32'(busy), 32'd0);
        chk($sformatf("u%0d_sig", id), 32'(sig), 32'(cur[id].sig));
        chk($sformatf("u%0d_pass", id), 32'(pass), 32'(cur[id].pass));
        chk($sformatf("u%0d_pat_trace_bad_cycles", id), 32'(nbad[id]), 32'd0);
      end else if (!busy) begin
        chk($sformatf("u%0d_busy_without_done", id), 32'(busy), 32'd1);
        qpop(id);
        act[id] = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, busy0, done0, pass0, pat0, sig0);
    mon(1, busy1, done1, pass1, pat1, sig1);
  end

  task automatic set_start(input int id, input logic v);
    if (id == 0) start0 = v;
    else         start1 = v;
  endtask

  // Starts n back-to-back runs (START held high throughout) and waits for all results.
  task automatic go(input int id, input logic stuck, input int n);
    int unsigned k, st, period;
    rec_t rec;
    @(negedge clk);
    if (id == 0) stuck0 = stuck;
    else         stuck1 = stuck;
    st     = (id == 0) ? 2 : 0;
    period = 8 * (st + 1) + 2;
    k      = cyc + 1;
    for (int i = 0; i < n; i++) begin
      rec.k    = k + i * period;
      rec.st   = st;
      rec.sig  = stuck ? 16'h0000 : EXP;
      rec.pass = !stuck;
      if (id == 0) q0.push_back(rec);
      else         q1.push_back(rec);
    end
    set_start(id, 1'b1);
    @(negedge clk);
    while (cyc < k + (n - 1) * period) @(negedge clk);
    set_start(id, 1'b0);
    for (int t = 0; t < 300 && qsize(id) != 0; t++) @(negedge clk);
    if (qsize(id) != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL u%0d_timeout: %0d results outstanding, expected 0", id, qsize(id));
      if (id == 0) q0.delete();
      else         q1.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pat0"},  32'(pat0),  32'd0);
    chk({tag, "_sig0"},  32'(sig0),  32'd0);
    chk({tag, "_busy0"}, 32'(busy0), 32'd0);
    chk({tag, "_done0"}, 32'(done0), 32'd0);
    chk({tag, "_pass0"}, 32'(pass0), 32'd0);
    chk({tag, "_pat1"},  32'(pat1),  32'd0);
    chk({tag, "_sig1"},  32'(sig1),  32'd0);
    chk({tag, "_pass1"}, 32'(pass1), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    rec_t rec;
    r = 1'b0; start0 = 1'b0; start1 = 1'b0;
    stuck0 = 1'b0; stuck1 = 1'b0; glitch_en = 1'b0; g = 1'b0;
    act[0] = 1'b0; act[1] = 1'b0; hold[0] = 1'b0; hold[1] = 1'b0;
    nbad[0] = 0; nbad[1] = 0;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk); #2 r = 1'b1;

    glitch_en = 1'b1;
    go(0, 1'b0, 1);
    glitch_en = 1'b0;
    go(0, 1'b1, 1);
    go(0, 1'b0, 1);
    go(1, 1'b0, 1);
    go(1, 1'b1, 1);
    go(1, 1'b0, 1);

    // Asynchronous reset while u0 holds pattern 4, then a clean restart.
    @(negedge clk);
    k = cyc + 1;
    rec.k = k; rec.st = 2; rec.sig = EXP; rec.pass = 1'b1;
    q0.push_back(rec);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    while (cyc < k + 13) @(negedge clk);
    chk("pre_reset_pat0", 32'(pat0), 32'(fpat(4)));
    #2 r = 1'b0;
    #1 chk_reset_outputs("midrun_reset");
    q0.delete();
    @(negedge clk); #2 r = 1'b1;
    go(0, 1'b0, 1);

    go(0, 1'b0, 3);
    go(1, 1'b0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
